// File: rtl/taxi_baser_pkg.sv
// rtl/taxi_baser_pkg.sv - 10GBASE-R receive decode constants and helpers
package taxi_baser_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] BLOCK_TYPE_CTRL     = 8'h1e;
  localparam logic [7:0] BLOCK_TYPE_START_0  = 8'h78;
  localparam logic [7:0] BLOCK_TYPE_CTRL_S_4 = 8'h33;
  localparam logic [7:0] BLOCK_TYPE_OS_S_4   = 8'h66;
  localparam logic [7:0] BLOCK_TYPE_OS_OS    = 8'h55;
  localparam logic [7:0] BLOCK_TYPE_OS_C     = 8'h4b;
  localparam logic [7:0] BLOCK_TYPE_TERM_0   = 8'h87;
  localparam logic [7:0] BLOCK_TYPE_TERM_1   = 8'h99;
  localparam logic [7:0] BLOCK_TYPE_TERM_2   = 8'haa;
  localparam logic [7:0] BLOCK_TYPE_TERM_3   = 8'hb4;
  localparam logic [7:0] BLOCK_TYPE_TERM_4   = 8'hcc;
  localparam logic [7:0] BLOCK_TYPE_TERM_5   = 8'hd2;
  localparam logic [7:0] BLOCK_TYPE_TERM_6   = 8'he1;
  localparam logic [7:0] BLOCK_TYPE_TERM_7   = 8'hff;

  localparam logic [6:0] CTRL_IDLE  = 7'h00;
  localparam logic [6:0] CTRL_ERROR = 7'h1e;
  localparam logic [3:0] O_SEQ_OS   = 4'h0;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hfb;
  localparam logic [7:0] XGMII_TERM  = 8'hfd;
  localparam logic [7:0] XGMII_ERROR = 8'hfe;
  localparam logic [7:0] XGMII_SEQ   = 8'h9c;

  localparam logic [63:0] XGMII_ERROR_WORD = {8{XGMII_ERROR}};
  localparam logic [63:0] XGMII_IDLE_WORD  = {8{XGMII_IDLE}};

  typedef enum logic {STATE_C, STATE_D} frame_state_t;
  typedef enum logic [1:0] {KIND_C, KIND_S, KIND_D, KIND_T} block_kind_t;

  // Returns {is_terminate, lane_of_T}.
  function automatic logic [3:0] term_lane(input logic [7:0] block_type);
    case (block_type)
      BLOCK_TYPE_TERM_0: term_lane = 4'b1_000;
      BLOCK_TYPE_TERM_1: term_lane = 4'b1_001;
      BLOCK_TYPE_TERM_2: term_lane = 4'b1_010;
      BLOCK_TYPE_TERM_3: term_lane = 4'b1_011;
      BLOCK_TYPE_TERM_4: term_lane = 4'b1_100;
      BLOCK_TYPE_TERM_5: term_lane = 4'b1_101;
      BLOCK_TYPE_TERM_6: term_lane = 4'b1_110;
      BLOCK_TYPE_TERM_7: term_lane = 4'b1_111;
      default:           term_lane = 4'b0_000;
    endcase
  endfunction

endpackage

// File: rtl/taxi_baser_ctrl_code_dec.sv
// rtl/taxi_baser_ctrl_code_dec.sv - 7-bit 64b/66b control code to XGMII character
module taxi_baser_ctrl_code_dec
  import taxi_baser_pkg::*;
(
  input  logic [6:0] code,
  output logic [7:0] xgmii_char,
  output logic       invalid
);

  always_comb begin
    xgmii_char = XGMII_ERROR;
    invalid    = 1'b1;
    case (code)
      CTRL_IDLE: begin
        xgmii_char = XGMII_IDLE;
        invalid    = 1'b0;
      end
      CTRL_ERROR: begin
        xgmii_char = XGMII_ERROR;
        invalid    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/taxi_xgmii_baser_dec_64.sv
// rtl/taxi_xgmii_baser_dec_64.sv - 10GBASE-R 64b/66b block to 64-bit XGMII receive decoder
module taxi_xgmii_baser_dec_64
  import taxi_baser_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = DATA_W / 8,
  parameter int HDR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] encoded_rx_data,
  input  logic              encoded_rx_data_valid,
  input  logic [HDR_W-1:0]  encoded_rx_hdr,
  input  logic              encoded_rx_hdr_valid,
  output logic [DATA_W-1:0] xgmii_rxd,
  output logic [CTRL_W-1:0] xgmii_rxc,
  output logic              rx_bad_block,
  output logic              rx_sequence_error
);

  if (DATA_W != 64) begin : g_bad_data_w
    $fatal(1, "DATA_W must be 64");
  end
  if (HDR_W != 2) begin : g_bad_hdr_w
    $fatal(1, "HDR_W must be 2");
  end
  if (CTRL_W != DATA_W / 8) begin : g_bad_ctrl_w
    $fatal(1, "CTRL_W must be DATA_W/8");
  end

  logic [7:0]  code_char [8];
  logic [7:0]  code_bad;

  for (genvar n = 0; n < 8; n++) begin : g_lane
    taxi_baser_ctrl_code_dec u_code_dec (
      .code      (encoded_rx_data[8+7*n +: 7]),
      .xgmii_char(code_char[n]),
      .invalid   (code_bad[n])
    );
  end

  logic [63:0]  dec_rxd;
  logic [7:0]   dec_rxc;
  logic         dec_bad;
  block_kind_t  dec_kind;
  logic [7:0]   code_used;
  logic         o_bad;
  logic [7:0]   blk_type;
  logic [3:0]   term;
  logic [63:0]  payload;

  always_comb begin
    dec_rxd   = XGMII_ERROR_WORD;
    dec_rxc   = 8'hff;
    dec_bad   = 1'b0;
    dec_kind  = KIND_C;
    code_used = 8'h00;
    o_bad     = 1'b0;
    blk_type  = encoded_rx_data[7:0];
    term      = term_lane(blk_type);
    // Payload bytes after the type byte, realigned so lane n data is payload[8n +: 8].
    payload   = {8'h00, encoded_rx_data[63:8]};

    if (encoded_rx_hdr == SYNC_DATA) begin
      dec_rxd  = encoded_rx_data;
      dec_rxc  = 8'h00;
      dec_kind = KIND_D;
    end else if (encoded_rx_hdr == SYNC_CTRL) begin
      case (blk_type)
        BLOCK_TYPE_CTRL: begin
          for (int n = 0; n < 8; n++) dec_rxd[8*n +: 8] = code_char[n];
          code_used = 8'hff;
        end
        BLOCK_TYPE_START_0: begin
          dec_rxd  = {encoded_rx_data[63:8], XGMII_START};
          dec_rxc  = 8'h01;
          dec_kind = KIND_S;
        end
        BLOCK_TYPE_CTRL_S_4: begin
          for (int n = 0; n < 4; n++) dec_rxd[8*n +: 8] = code_char[n];
          dec_rxd[63:32] = {encoded_rx_data[63:40], XGMII_START};
          dec_rxc   = 8'h1f;
          code_used = 8'h0f;
          dec_kind  = KIND_S;
        end
        BLOCK_TYPE_OS_S_4: begin
          dec_rxd  = {encoded_rx_data[63:40], XGMII_START, encoded_rx_data[31:8], XGMII_SEQ};
          dec_rxc  = 8'h11;
          o_bad    = encoded_rx_data[35:32] != O_SEQ_OS;
          dec_kind = KIND_S;
        end
        BLOCK_TYPE_OS_OS: begin
          dec_rxd = {encoded_rx_data[63:40], XGMII_SEQ, encoded_rx_data[31:8], XGMII_SEQ};
          dec_rxc = 8'h11;
          o_bad   = (encoded_rx_data[35:32] != O_SEQ_OS) || (encoded_rx_data[39:36] != O_SEQ_OS);
        end
        BLOCK_TYPE_OS_C: begin
          for (int n = 4; n < 8; n++) dec_rxd[8*n +: 8] = code_char[n];
          dec_rxd[31:0] = {encoded_rx_data[31:8], XGMII_SEQ};
          dec_rxc   = 8'hf1;
          code_used = 8'hf0;
          o_bad     = encoded_rx_data[35:32] != O_SEQ_OS;
        end
        default: begin
          if (term[3]) begin
            for (int n = 0; n < 8; n++) begin
              if (n < int'(term[2:0])) begin
                dec_rxd[8*n +: 8] = payload[8*n +: 8];
              end else if (n == int'(term[2:0])) begin
                dec_rxd[8*n +: 8] = XGMII_TERM;
              end else begin
                dec_rxd[8*n +: 8] = code_char[n];
                code_used[n]      = 1'b1;
              end
            end
            dec_rxc  = 8'hff << term[2:0];
            dec_kind = KIND_T;
          end else begin
            dec_bad = 1'b1;
          end
        end
      endcase
    end else begin
      dec_bad = 1'b1;
    end

    dec_bad = dec_bad | (|(code_bad & code_used)) | o_bad;
  end

  logic [63:0]  rxd_q, rxd_d;
  logic [7:0]   rxc_q, rxc_d;
  logic         bad_q, bad_d;
  logic         seq_q, seq_d;
  frame_state_t state_q, state_d;
  logic         seq_err;

  always_comb begin
    rxd_d   = rxd_q;
    rxc_d   = rxc_q;
    bad_d   = 1'b0;
    seq_d   = 1'b0;
    state_d = state_q;
    seq_err = 1'b0;

    if (encoded_rx_data_valid && encoded_rx_hdr_valid) begin
      if (dec_bad) begin
        rxd_d   = XGMII_ERROR_WORD;
        rxc_d   = 8'hff;
        bad_d   = 1'b1;
        state_d = STATE_C;
      end else begin
        if (state_q == STATE_C) begin
          case (dec_kind)
            KIND_S:  state_d = STATE_D;
            KIND_C:  state_d = STATE_C;
            default: seq_err = 1'b1;
          endcase
        end else begin
          case (dec_kind)
            KIND_D:  state_d = STATE_D;
            KIND_T:  state_d = STATE_C;
            default: seq_err = 1'b1;
          endcase
        end

        if (seq_err) begin
          rxd_d   = XGMII_ERROR_WORD;
          rxc_d   = 8'hff;
          seq_d   = 1'b1;
          state_d = STATE_C;
        end else begin
          rxd_d = dec_rxd;
          rxc_d = dec_rxc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_q   <= XGMII_IDLE_WORD;
      rxc_q   <= 8'hff;
      bad_q   <= 1'b0;
      seq_q   <= 1'b0;
      state_q <= STATE_C;
    end else begin
      rxd_q   <= rxd_d;
      rxc_q   <= rxc_d;
      bad_q   <= bad_d;
      seq_q   <= seq_d;
      state_q <= state_d;
    end
  end

  assign xgmii_rxd         = rxd_q;
  assign xgmii_rxc         = rxc_q;
  assign rx_bad_block      = bad_q;
  assign rx_sequence_error = seq_q;

endmodule
